// File: rtl/preg_alloc_ctrl_pkg.sv
// Shared types for the rename-stage physical-register freelist controller.
// Width constants and the branch tag type are common with the freelist and ROB.
package preg_alloc_ctrl_pkg;
  localparam int NUM_PREGS_DEF   = 64;
  localparam int MAX_DEPTH_DEF   = 4;
  localparam int FREEQ_DEPTH_DEF = 8;
  localparam int PREG_W          = $clog2(NUM_PREGS_DEF);
  localparam int TAG_W           = $clog2(MAX_DEPTH_DEF + 1);

  typedef logic [TAG_W-1:0]  tag_t;
  typedef logic [PREG_W-1:0] preg_t;

  typedef enum logic [1:0] {
    ST_INIT,
    ST_RUN,
    ST_SHOOT,
    ST_SETTLE
  } state_e;
endpackage

// File: rtl/preg_alloc_ctrl_free_queue.sv
// Retire-side free queue: 3 pushes in, up to 2 registered pops out per cycle.
// Entries pushed at an edge may be popped at that same edge (bypass onto the free ports).
module preg_alloc_ctrl_free_queue
  import preg_alloc_ctrl_pkg::*;
#(
  parameter int DEPTH = FREEQ_DEPTH_DEF,
  parameter int PW    = PREG_W
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [2:0]    push_valid,
  input  logic [PW-1:0] push_preg0,
  input  logic [PW-1:0] push_preg1,
  input  logic [PW-1:0] push_preg2,
  input  logic          pop_en,
  output logic          room,
  output logic          free1,
  output logic          free2,
  output logic [PW-1:0] free1_addr,
  output logic [PW-1:0] free2_addr
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [PW-1:0] mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count, avail;
  logic [1:0]    npush, npop;
  logic [PW-1:0] p [3];
  logic [PW-1:0] head0, head1;
  logic [PW-1:0] addr1_q, addr2_q;

  assign room = (count + CW'(3)) <= CW'(DEPTH);

  // Compact the sparse retire lanes so they land in consecutive slots, lane order kept.
  always_comb begin
    npush = {1'b0, push_valid[0]} + {1'b0, push_valid[1]} + {1'b0, push_valid[2]};
    p[0]  = push_valid[0] ? push_preg0 : (push_valid[1] ? push_preg1 : push_preg2);
    p[1]  = (push_valid[0] && push_valid[1]) ? push_preg1 : push_preg2;
    p[2]  = push_preg2;
    avail = count + CW'(npush);
    npop  = 2'd0;
    if (pop_en) npop = (avail >= CW'(2)) ? 2'd2 : avail[1:0];
    head0 = (count >= CW'(1)) ? mem[rd_ptr] : p[0];
    head1 = (count >= CW'(2)) ? mem[rd_ptr + AW'(1)] :
            ((count == CW'(1)) ? p[0] : p[1]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      free1  <= 1'b0;
      free2  <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr + AW'(npush);
      rd_ptr <= rd_ptr + AW'(npop);
      count  <= avail - CW'(npop);
      free1  <= npop != 2'd0;
      free2  <= npop == 2'd2;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (2'(i) < npush) mem[wr_ptr + AW'(i)] <= p[i];
    end
    addr1_q <= head0;
    addr2_q <= head1;
  end

  assign free1_addr = free1 ? addr1_q : '0;
  assign free2_addr = free2 ? addr2_q : '0;
endmodule

// File: rtl/preg_alloc_ctrl.sv
// Freelist sequencing controller: two-lane allocation arbitration, branch tag depth
// tracking, mispredict shootdown/recovery sequencing and the retire free queue.
module preg_alloc_ctrl
  import preg_alloc_ctrl_pkg::*;
#(
  parameter int NUM_PREGS         = NUM_PREGS_DEF,
  parameter int MAX_PREDICT_DEPTH = MAX_DEPTH_DEF,
  parameter int FREEQ_DEPTH       = FREEQ_DEPTH_DEF,
  localparam int PW = $clog2(NUM_PREGS),
  localparam int TW = $clog2(MAX_PREDICT_DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [1:0]    req_valid,
  input  logic [1:0]    req_is_branch,
  output logic          req_ready,
  output logic [PW-1:0] grant_preg0,
  output logic [PW-1:0] grant_preg1,
  output logic [TW-1:0] grant_tag0,
  output logic [TW-1:0] grant_tag1,
  input  logic [PW:0]   fl_num_free,
  input  logic [PW-1:0] fl_preg1,
  input  logic [PW-1:0] fl_preg2,
  output logic [1:0]    alloc_num,
  output logic [TW-1:0] branch_tag_1,
  output logic [TW-1:0] branch_tag_2,
  output logic          free1,
  output logic          free2,
  output logic [PW-1:0] free1_addr,
  output logic [PW-1:0] free2_addr,
  output logic          branch_shootdown,
  output logic [TW-1:0] shootdown_branch_tag,
  input  logic [2:0]    ret_valid,
  input  logic [PW-1:0] ret_preg0,
  input  logic [PW-1:0] ret_preg1,
  input  logic [PW-1:0] ret_preg2,
  output logic          ret_ready,
  input  logic          br_valid,
  input  logic          br_mispredict,
  input  logic [TW-1:0] br_tag,
  output logic          busy
);
  state_e        state_q;
  logic [TW-1:0] depth_q;
  logic [TW-1:0] shoot_tag_q;

  logic [1:0]    need, nbr;
  logic          mispredict, grant, q_room;
  logic [TW:0]   depth_sum;

  always_comb begin
    need       = {1'b0, req_valid[0]} + {1'b0, req_valid[1]};
    nbr        = {1'b0, req_valid[0] & req_is_branch[0]} +
                 {1'b0, req_valid[1] & req_is_branch[1]};
    mispredict = br_valid && br_mispredict;
    grant      = !reset && (state_q == ST_RUN) && !mispredict &&
                 (fl_num_free >= (PW+1)'(need)) &&
                 ((TW+1)'(depth_q) + (TW+1)'(nbr) <= (TW+1)'(MAX_PREDICT_DEPTH));
    // Grant and correct-resolve deltas combine; the decrement saturates at zero.
    depth_sum  = (TW+1)'(depth_q) + (grant ? (TW+1)'(nbr) : '0);
    if (br_valid && !br_mispredict && depth_sum != '0) depth_sum = depth_sum - (TW+1)'(1);
  end

  assign req_ready    = grant;
  assign alloc_num    = grant ? need : 2'd0;
  assign grant_preg0  = fl_preg1;
  assign grant_preg1  = fl_preg2;
  assign grant_tag0   = (grant && req_valid[0]) ? depth_q : '0;
  assign grant_tag1   = (grant && req_valid[1]) ? depth_q + TW'(req_is_branch[0]) : '0;
  assign branch_tag_1 = grant_tag0;
  assign branch_tag_2 = grant_tag1;

  assign branch_shootdown     = state_q == ST_SHOOT;
  assign shootdown_branch_tag = (state_q == ST_SHOOT) ? shoot_tag_q : '0;
  assign busy                 = state_q != ST_RUN;
  assign ret_ready            = !reset && (state_q != ST_INIT) && q_room;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_INIT;
      depth_q     <= '0;
      shoot_tag_q <= '0;
    end else begin
      unique case (state_q)
        ST_INIT: state_q <= ST_RUN;
        ST_RUN: begin
          if (mispredict) begin
            shoot_tag_q <= br_tag;
            depth_q     <= br_tag - TW'(1);
            state_q     <= ST_SHOOT;
          end else begin
            depth_q <= depth_sum[TW-1:0];
          end
        end
        ST_SHOOT, ST_SETTLE: begin
          // An older branch mispredicting during recovery restarts the shootdown.
          if (mispredict && br_tag < shoot_tag_q) begin
            shoot_tag_q <= br_tag;
            depth_q     <= br_tag - TW'(1);
            state_q     <= ST_SHOOT;
          end else begin
            state_q <= (state_q == ST_SHOOT) ? ST_SETTLE : ST_RUN;
          end
        end
        default: state_q <= ST_INIT;
      endcase
    end
  end

  preg_alloc_ctrl_free_queue #(
    .DEPTH (FREEQ_DEPTH),
    .PW    (PW)
  ) u_free_queue (
    .clk        (clk),
    .reset      (reset),
    .push_valid (ret_valid & {3{ret_ready}}),
    .push_preg0 (ret_preg0),
    .push_preg1 (ret_preg1),
    .push_preg2 (ret_preg2),
    .pop_en     (state_q != ST_INIT),
    .room       (q_room),
    .free1      (free1),
    .free2      (free2),
    .free1_addr (free1_addr),
    .free2_addr (free2_addr)
  );
endmodule

// File: tb/tb_preg_alloc_ctrl.sv
// Scoreboard bench for preg_alloc_ctrl: stimulus pushes expected per-cycle responses
// and freed pregs into queues; a negedge monitor pops and compares.
module tb_preg_alloc_ctrl;
  localparam int PW = 6;
  localparam int TW = 3;
  localparam int MAXD = 4;
  localparam int QD = 8;
  localparam int PH_INIT = 0, PH_RUN = 1, PH_SHOOT = 2, PH_SETTLE = 3;

  logic          clk, reset;
  logic [1:0]    req_valid, req_is_branch;
  logic          req_ready;
  logic [PW-1:0] grant_preg0, grant_preg1;
  logic [TW-1:0] grant_tag0, grant_tag1;
  logic [PW:0]   fl_num_free;
  logic [PW-1:0] fl_preg1, fl_preg2;
  logic [1:0]    alloc_num;
  logic [TW-1:0] branch_tag_1, branch_tag_2;
  logic          free1, free2;
  logic [PW-1:0] free1_addr, free2_addr;
  logic          branch_shootdown;
  logic [TW-1:0] shootdown_branch_tag;
  logic [2:0]    ret_valid;
  logic [PW-1:0] ret_preg0, ret_preg1, ret_preg2;
  logic          ret_ready;
  logic          br_valid, br_mispredict;
  logic [TW-1:0] br_tag;
  logic          busy;

  preg_alloc_ctrl dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_is_branch(req_is_branch), .req_ready(req_ready),
    .grant_preg0(grant_preg0), .grant_preg1(grant_preg1),
    .grant_tag0(grant_tag0), .grant_tag1(grant_tag1),
    .fl_num_free(fl_num_free), .fl_preg1(fl_preg1), .fl_preg2(fl_preg2),
    .alloc_num(alloc_num), .branch_tag_1(branch_tag_1), .branch_tag_2(branch_tag_2),
    .free1(free1), .free2(free2), .free1_addr(free1_addr), .free2_addr(free2_addr),
    .branch_shootdown(branch_shootdown), .shootdown_branch_tag(shootdown_branch_tag),
    .ret_valid(ret_valid), .ret_preg0(ret_preg0), .ret_preg1(ret_preg1), .ret_preg2(ret_preg2),
    .ret_ready(ret_ready),
    .br_valid(br_valid), .br_mispredict(br_mispredict), .br_tag(br_tag),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int ready, alloc, tag0, tag1, shoot, stag, busy, rready, nfree, gp0, gp1;
  } exp_t;

  exp_t rec_q[$];
  int   addr_q[$];
  int   tests = 0;
  int   fails = 0;

  // Reference model: phase is derived from cycles elapsed since reset and since the
  // last accepted mispredict; the free queue is a plain list of pending pregs.
  int m_cyc, m_last_mp, m_T, m_depth, m_nfree;
  int m_fq[$];

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_free_addr(input string name, input int act);
    if (addr_q.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL %s: got unexpected free of %0d, expected no free (t=%0t)", name, act, $time);
    end else begin
      check(name, act, addr_q.pop_front());
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rec_q.size() > 0) begin
      e = rec_q.pop_front();
      check("req_ready", int'(req_ready), e.ready);
      check("alloc_num", int'(alloc_num), e.alloc);
      check("grant_tag0", int'(grant_tag0), e.tag0);
      check("grant_tag1", int'(grant_tag1), e.tag1);
      check("branch_tag_1", int'(branch_tag_1), e.tag0);
      check("branch_tag_2", int'(branch_tag_2), e.tag1);
      check("grant_preg0", int'(grant_preg0), e.gp0);
      check("grant_preg1", int'(grant_preg1), e.gp1);
      check("branch_shootdown", int'(branch_shootdown), e.shoot);
      check("shootdown_tag", int'(shootdown_branch_tag), e.stag);
      check("busy", int'(busy), e.busy);
      check("ret_ready", int'(ret_ready), e.rready);
      check("free_count", int'(free1) + int'(free2), e.nfree);
      if (free2) check("free2_implies_free1", int'(free1), 1);
      if (free1) check_free_addr("free1_addr", int'(free1_addr));
      if (free2) check_free_addr("free2_addr", int'(free2_addr));
    end
  end

  function automatic int phase();
    if (m_cyc == 0) return PH_INIT;
    if (m_cyc - m_last_mp == 1) return PH_SHOOT;
    if (m_cyc - m_last_mp == 2) return PH_SETTLE;
    return PH_RUN;
  endfunction

  task automatic model_reset();
    m_cyc = 0; m_last_mp = -100; m_T = 0; m_depth = 0; m_nfree = 0;
    m_fq.delete();
  endtask

  task automatic step(input bit r, input bit [1:0] rv, input bit [1:0] rb, input int nf,
                      input bit bv, input bit bm, input int bt, input bit [2:0] retv);
    exp_t e;
    int ph, need, nbr, gok, d;
    int lanes[3];
    reset = r; req_valid = rv; req_is_branch = rb; fl_num_free = 7'(nf);
    fl_preg1 = 6'($urandom); fl_preg2 = 6'($urandom);
    br_valid = bv; br_mispredict = bm; br_tag = 3'(bt);
    ret_valid = retv;
    ret_preg0 = 6'($urandom); ret_preg1 = 6'($urandom); ret_preg2 = 6'($urandom);
    lanes[0] = int'(ret_preg0); lanes[1] = int'(ret_preg1); lanes[2] = int'(ret_preg2);

    ph   = phase();
    need = int'(rv[0]) + int'(rv[1]);
    nbr  = int'(rv[0] & rb[0]) + int'(rv[1] & rb[1]);
    gok  = (ph == PH_RUN && !r && !(bv && bm) && nf >= need && m_depth + nbr <= MAXD) ? 1 : 0;
    e.ready  = gok;
    e.alloc  = gok ? need : 0;
    e.tag0   = (gok && rv[0]) ? m_depth : 0;
    e.tag1   = (gok && rv[1]) ? m_depth + int'(rb[0]) : 0;
    e.shoot  = (ph == PH_SHOOT) ? 1 : 0;
    e.stag   = (ph == PH_SHOOT) ? m_T : 0;
    e.busy   = (ph != PH_RUN) ? 1 : 0;
    e.rready = (ph != PH_INIT && !r && m_fq.size() + 3 <= QD) ? 1 : 0;
    e.nfree  = m_nfree;
    e.gp0    = int'(fl_preg1);
    e.gp1    = int'(fl_preg2);
    rec_q.push_back(e);

    if (r) begin
      model_reset();
    end else begin
      if (e.rready == 1)
        for (int i = 0; i < 3; i++) if (retv[i]) m_fq.push_back(lanes[i]);
      m_nfree = 0;
      if (ph != PH_INIT)
        while (m_nfree < 2 && m_fq.size() > 0) begin
          addr_q.push_back(m_fq.pop_front());
          m_nfree++;
        end
      if (ph == PH_RUN) begin
        if (bv && bm) begin
          m_T = bt; m_depth = bt - 1; m_last_mp = m_cyc;
        end else begin
          d = m_depth + (gok ? nbr : 0);
          if (bv && d > 0) d--;
          m_depth = d;
        end
      end else if (ph == PH_SHOOT || ph == PH_SETTLE) begin
        if (bv && bm && bt < m_T) begin
          m_T = bt; m_depth = bt - 1; m_last_mp = m_cyc;
        end
      end
      m_cyc++;
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int sel, bt, waitc;
    bit r, bv, bm;
    bit [1:0] rv, rb;
    reset = 1'b1; req_valid = '0; req_is_branch = '0; fl_num_free = '0;
    fl_preg1 = '0; fl_preg2 = '0; br_valid = 0; br_mispredict = 0; br_tag = '0;
    ret_valid = '0; ret_preg0 = '0; ret_preg1 = '0; ret_preg2 = '0;
    repeat (3) @(posedge clk);
    #1;
    model_reset();

    // Reset state, then a full two-lane grant.
    step(0, 2'b00, 2'b00, 64, 0, 0, 1, 3'b000);
    step(0, 2'b11, 2'b00, 64, 0, 0, 1, 3'b000);
    // Free-count stall, then a single-lane grant.
    step(0, 2'b11, 2'b00, 1, 0, 0, 1, 3'b000);
    step(0, 2'b01, 2'b00, 1, 0, 0, 1, 3'b000);
    // Build depth 3, stall at the depth limit, resolve, then grant tags 2/3.
    step(0, 2'b11, 2'b11, 64, 0, 0, 1, 3'b000);
    step(0, 2'b01, 2'b01, 64, 0, 0, 1, 3'b000);
    step(0, 2'b11, 2'b11, 64, 0, 0, 1, 3'b000);
    step(0, 2'b11, 2'b11, 64, 1, 0, 1, 3'b000);
    step(0, 2'b11, 2'b11, 64, 0, 0, 1, 3'b000);
    // Mispredict tag 2, then an older mispredict (tag 1) during SETTLE.
    step(0, 2'b11, 2'b00, 64, 1, 1, 2, 3'b000);
    step(0, 2'b11, 2'b00, 64, 0, 0, 1, 3'b000);
    step(0, 2'b11, 2'b00, 64, 1, 1, 1, 3'b000);
    step(0, 2'b11, 2'b00, 64, 0, 0, 1, 3'b000);
    step(0, 2'b11, 2'b00, 64, 0, 0, 1, 3'b000);
    step(0, 2'b01, 2'b00, 64, 0, 0, 1, 3'b000);
    // Saturate the retire queue across pointer wrap, then drain.
    repeat (8) step(0, 2'b00, 2'b00, 64, 0, 0, 1, 3'b111);
    repeat (4) step(0, 2'b00, 2'b00, 64, 0, 0, 1, 3'b000);
    // Reset with five queued frees pending.
    repeat (5) step(0, 2'b00, 2'b00, 64, 0, 0, 1, 3'b111);
    step(1, 2'b00, 2'b00, 64, 0, 0, 1, 3'b000);
    repeat (4) step(0, 2'b11, 2'b00, 64, 0, 0, 1, 3'b000);

    // Randomized traffic.
    for (int n = 0; n < 2500; n++) begin
      r   = ($urandom_range(0, 199) == 0);
      sel = $urandom_range(0, 3);
      rv  = (sel == 0) ? 2'b00 : ((sel == 1) ? 2'b01 : 2'b11);
      rb  = 2'($urandom) & rv;
      bv  = ($urandom_range(0, 3) == 0) && (m_depth > 0 || phase() != PH_RUN);
      bm  = bv && ($urandom_range(0, 4) == 0);
      if (bm) bt = (phase() == PH_RUN) ? $urandom_range(1, (m_depth > 0) ? m_depth : 1)
                                       : $urandom_range(1, m_depth + 1);
      else bt = 1;
      step(r, rv, rb, ($urandom_range(0, 3) == 0) ? $urandom_range(0, 2) : $urandom_range(0, 64),
           bv, bm, bt, 3'($urandom));
    end

    repeat (8) step(0, 2'b00, 2'b00, 64, 0, 0, 1, 3'b000);
    waitc = 0;
    while (rec_q.size() > 0 && waitc < 10) begin
      @(posedge clk);
      waitc++;
    end
    check("records_consumed", rec_q.size(), 0);
    check("frees_outstanding", addr_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
